// File: rtl/bit_sched.sv
// bit_sched: serialises the set bits of a request word into a
// stream of bit indices, highest index first.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   in_valid/ready  request word handshake (in_ready high in IDLE)
//   in_data         request vector, bit i = requester i
//   out_valid/ready index handshake (out_valid high in SCAN)
//   out_idx         highest remaining set bit, WIDTH = none set
//   out_last        current index is the final one for the word
//   abort           synchronous flush of the word in flight
//   busy            high in SCAN
//   pending         remaining set-bit count (BIT_SCHED_PENDING_EN)
//
// Optional feature macro: BIT_SCHED_PENDING_EN
module bit_sched #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   input  logic             abort,
   output logic             busy
`ifdef BIT_SCHED_PENDING_EN
   ,
   output logic [IDXW-1:0]  pending
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mask_q, mask_d;

   logic [IDXW-1:0]  lead_idx;
   logic             one_or_less;

   // Leading-one encoder: ascending scan so the highest set bit wins.
   // An empty mask yields the "none" code WIDTH.
   always_comb begin
      lead_idx = IDXW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (mask_q[i]) begin
            lead_idx = IDXW'(i);
         end
      end
   end

   // popcount(mask) <= 1 without a full adder tree.
   assign one_or_less = ((mask_q & (mask_q - WIDTH'(1))) == '0);

`ifdef BIT_SCHED_PENDING_EN
   logic [IDXW-1:0] pop_cnt;

   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_cnt = pop_cnt + IDXW'(mask_q[i]);
      end
   end

   // mask is held at zero in IDLE, so this is already 0 there.
   assign pending = (state_q == SCAN) ? pop_cnt : '0;
`endif

   // Output decode: everything depends on state and mask only.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         SCAN: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            busy      = 1'b1;
            out_idx   = lead_idx;
            out_last  = one_or_less;
         end
         default: begin
            in_ready = 1'b1;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      unique case (state_q)
         IDLE: begin
            // abort wins over an offered word
            if (!abort && in_valid) begin
               mask_d  = in_data;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               // any same-cycle handshake is discarded
               mask_d  = '0;
               state_d = IDLE;
            end else if (out_ready) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (IDXW'(i) == lead_idx) begin
                     mask_d[i] = 1'b0;
                  end
               end
               if (one_or_less) begin
                  mask_d  = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            mask_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

endmodule
